// File: rtl/fifo_pkg.sv
// Shared helpers for the FWFT commit/rewind FIFO: pointer arithmetic and flag thresholds.
// All arithmetic is done in a fixed 32-bit counting domain.
// Callers zero-extend their pointers, and the result is masked back to the pointer width.
package fifo_pkg;

   // Width of the counting domain used by the helpers below.
   localparam int unsigned CNT_W = 32;

   typedef logic [CNT_W-1:0] cnt_t;

   // Status flags, registered together in the FIFO top.
   typedef struct packed {
      logic almost_full_2;
      logic almost_full;
      logic full;
      logic almost_empty;
      logic empty;
   } flags_t;

   // Flag values while reset is applied: nothing readable, nothing occupied.
   localparam flags_t FLAGS_RST = '{
      almost_full_2 : 1'b0,
      almost_full   : 1'b0,
      full          : 1'b0,
      almost_empty  : 1'b1,
      empty         : 1'b1
   };

   // Difference a-b of two wrap-bit pointers, taken modulo 2^ptr_w.
   // ptr_w is the full pointer width, including the wrap bit.
   function automatic cnt_t ptr_diff(input cnt_t a, input cnt_t b, input int unsigned ptr_w);
      cnt_t mask;
      mask = (cnt_t'(1) << ptr_w) - cnt_t'(1);
      return (a - b) & mask;
   endfunction

   // True once occupancy leaves free_thres or fewer free entries.
   function automatic logic at_fill_limit(input cnt_t occ, input cnt_t depth,
                                          input cnt_t free_thres);
      return occ >= (depth - free_thres);
   endfunction

   // Full flag set from committed occupancy and speculative readable count.
   function automatic flags_t calc_flags(input cnt_t occ, input cnt_t rd_cnt, input cnt_t depth,
                                         input cnt_t ae_thres, input cnt_t af_thres,
                                         input cnt_t af2_thres);
      flags_t f;
      f.empty         = (rd_cnt == '0);
      f.almost_empty  = (rd_cnt <= ae_thres);
      f.full          = (occ == depth);
      f.almost_full   = at_fill_limit(occ, depth, af_thres);
      f.almost_full_2 = at_fill_limit(occ, depth, af2_thres);
      return f;
   endfunction

endpackage

// File: rtl/ram_2p_regarray.sv
// Register-array storage with one write port and one read port.
// Ports: clk, wr_en_i/wr_addr_i/wr_data_i (written on the rising edge), rd_addr_i -> rd_data_o (combinational).
// Contents are not reset; callers must never expose an entry they have not written.
module ram_2p_regarray #(
   parameter int unsigned DW = 18,
   parameter int unsigned AW = 6
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);

   logic [DW-1:0] mem_q [1 << AW];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // The asynchronous read port is what gives the FIFO its first-word fall-through.
   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fwft_fifo_spec.sv
// Synchronous first-word-fall-through FIFO with speculative reads, commit and rewind.
// Ports: clk/res_n, shift_in+d_in write, shift_out/commit/rewind read control,
//        d_out head data, registered flags empty/almost_empty/full/almost_full/almost_full_2, level.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky err_overflow/err_underflow outputs.
// A word written is visible on d_out one edge later; writes while full and reads while empty are dropped.
module sync_fwft_fifo_spec #(
   parameter int unsigned DSIZE               = 18,
   parameter int unsigned ASIZE               = 6,
   parameter int unsigned ALMOST_EMPTY_THRES  = 1,
   parameter int unsigned ALMOST_FULL_THRES   = 1,
   parameter int unsigned ALMOST_FULL_THRES_2 = 4
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             shift_in,
   input  logic [DSIZE-1:0] d_in,
   input  logic             shift_out,
   input  logic             commit,
   input  logic             rewind,
   output logic [DSIZE-1:0] d_out,
   output logic             empty,
   output logic             almost_empty,
   output logic             full,
   output logic             almost_full,
   output logic             almost_full_2,
   output logic [ASIZE:0]   level
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic             err_overflow,
   output logic             err_underflow
`endif
);

   import fifo_pkg::*;

   localparam int unsigned DEPTH = 1 << ASIZE;
   localparam int unsigned PTR_W = ASIZE + 1;

   // Pointers carry a wrap bit in the MSB so that full and empty are distinguishable.
   logic [ASIZE:0] wptr_q, wptr_d;
   logic [ASIZE:0] rptr_q, rptr_d;   // speculative read position
   logic [ASIZE:0] cptr_q, cptr_d;   // last committed read position
   logic [ASIZE:0] level_q, level_d;
   flags_t         flags_q, flags_d;

   logic             wr_en;
   logic             rd_en;
   logic [DSIZE-1:0] rd_data;
   cnt_t             occ_d;
   cnt_t             rd_cnt_d;

   always_comb begin
      // Space only comes back through commit, so a write while full is
      // dropped even if a commit in the same cycle would free room.
      wr_en  = shift_in & ~flags_q.full;
      // Rewind overrides any read advance issued in the same cycle.
      rd_en  = shift_out & ~flags_q.empty & ~rewind;

      wptr_d = wptr_q + {{ASIZE{1'b0}}, wr_en};
      rptr_d = rptr_q;
      cptr_d = cptr_q;

      if (rewind) begin
         rptr_d = cptr_q;
      end else begin
         rptr_d = rptr_q + {{ASIZE{1'b0}}, rd_en};
         // Commit captures the post-advance read pointer, so a read in the
         // same cycle is released together with everything before it.
         if (commit) begin
            cptr_d = rptr_d;
         end
      end

      occ_d    = ptr_diff(cnt_t'(wptr_d), cnt_t'(cptr_d), PTR_W);
      rd_cnt_d = ptr_diff(cnt_t'(wptr_d), cnt_t'(rptr_d), PTR_W);
      flags_d  = calc_flags(occ_d, rd_cnt_d, cnt_t'(DEPTH),
                            cnt_t'(ALMOST_EMPTY_THRES),
                            cnt_t'(ALMOST_FULL_THRES),
                            cnt_t'(ALMOST_FULL_THRES_2));
      level_d  = occ_d[ASIZE:0];
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cptr_q  <= '0;
         level_q <= '0;
         flags_q <= FLAGS_RST;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cptr_q  <= cptr_d;
         level_q <= level_d;
         flags_q <= flags_d;
      end
   end

   ram_2p_regarray #(
      .DW (DSIZE),
      .AW (ASIZE)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wptr_q[ASIZE-1:0]),
      .wr_data_i (d_in),
      .rd_addr_i (rptr_q[ASIZE-1:0]),
      .rd_data_o (rd_data)
   );

   // Gating with the registered empty flag hides stale memory contents,
   // including immediately after an asynchronous reset.
   assign d_out         = flags_q.empty ? '0 : rd_data;
   assign empty         = flags_q.empty;
   assign almost_empty  = flags_q.almost_empty;
   assign full          = flags_q.full;
   assign almost_full   = flags_q.almost_full;
   assign almost_full_2 = flags_q.almost_full_2;
   assign level         = level_q;

`ifdef FIFO_ERR_FLAGS_EN
   logic err_ovf_q;
   logic err_unf_q;

   // Sticky until reset; they record attempts, not the accepted traffic.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         if (shift_in && flags_q.full) begin
            err_ovf_q <= 1'b1;
         end
         if (shift_out && flags_q.empty) begin
            err_unf_q <= 1'b1;
         end
      end
   end

   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_unf_q;
`endif

endmodule

// File: tb/tb_sync_fwft_fifo_spec.sv
// Directed self-checking bench for sync_fwft_fifo_spec (ASIZE=3, AF=1, AF2=3, AE=1).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Ports: none (top-level bench); prints one summary line at the end.
module tb_sync_fwft_fifo_spec;

   logic       clk = 1'b0;
   logic       res_n = 1'b1;
   logic       shift_in = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic       shift_out = 1'b0;
   logic       commit = 1'b0;
   logic       rewind = 1'b0;
   logic [7:0] d_out;
   logic       empty, almost_empty, full, almost_full, almost_full_2;
   logic [3:0] level;
`ifdef FIFO_ERR_FLAGS_EN
   logic       err_overflow, err_underflow;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fwft_fifo_spec #(
      .DSIZE               (8),
      .ASIZE               (3),
      .ALMOST_EMPTY_THRES  (1),
      .ALMOST_FULL_THRES   (1),
      .ALMOST_FULL_THRES_2 (3)
   ) dut (
      .clk           (clk),
      .res_n         (res_n),
      .shift_in      (shift_in),
      .d_in          (d_in),
      .shift_out     (shift_out),
      .commit        (commit),
      .rewind        (rewind),
      .d_out         (d_out),
      .empty         (empty),
      .almost_empty  (almost_empty),
      .full          (full),
      .almost_full   (almost_full),
      .almost_full_2 (almost_full_2),
      .level         (level)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus, then return 1 ns after the edge with inputs idle.
   task automatic cycle(input logic si, input logic [7:0] din, input logic so,
                        input logic cm, input logic rw);
      shift_in  = si;
      d_in      = din;
      shift_out = so;
      commit    = cm;
      rewind    = rw;
      @(posedge clk);
      #1;
      shift_in  = 1'b0;
      shift_out = 1'b0;
      commit    = 1'b0;
      rewind    = 1'b0;
   endtask

   logic [7:0] q[$];

   initial begin
      // Asynchronous reset, checked before any clock edge.
      #2 res_n = 1'b0;
      #1;
      chk("rst_empty",  32'(empty), 32'd1);
      chk("rst_aempty", 32'(almost_empty), 32'd1);
      chk("rst_full",   32'(full), 32'd0);
      chk("rst_afull",  32'(almost_full), 32'd0);
      chk("rst_afull2", 32'(almost_full_2), 32'd0);
      chk("rst_level",  32'(level), 32'd0);
      chk("rst_dout",   32'(d_out), 32'd0);
      @(posedge clk);
      #1 res_n = 1'b1;

      // Read while empty is ignored.
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("uf_empty", 32'(empty), 32'd1);
      chk("uf_level", 32'(level), 32'd0);
      chk("uf_dout",  32'(d_out), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("uf_err", 32'(err_underflow), 32'd1);
      chk("uf_ovf_clear", 32'(err_overflow), 32'd0);
`endif

      // Fill with 0x01..0x08.
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
         chk("fill_level",  32'(level), 32'(k));
         chk("fill_dout",   32'(d_out), 32'h01);
         chk("fill_empty",  32'(empty), 32'd0);
         chk("fill_aempty", 32'(almost_empty), 32'(k <= 1));
         chk("fill_afull2", 32'(almost_full_2), 32'(k >= 5));
         chk("fill_afull",  32'(almost_full), 32'(k >= 7));
         chk("fill_full",   32'(full), 32'(k == 8));
      end

      // Ninth write dropped.
      cycle(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
      chk("ovf_level", 32'(level), 32'd8);
      chk("ovf_full",  32'(full), 32'd1);
      chk("ovf_dout",  32'(d_out), 32'h01);
`ifdef FIFO_ERR_FLAGS_EN
      chk("ovf_err", 32'(err_overflow), 32'd1);
`endif

      // Speculative reads do not free space.
      for (int j = 1; j <= 3; j++) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         chk("spec_dout",  32'(d_out), 32'(j + 1));
         chk("spec_full",  32'(full), 32'd1);
         chk("spec_level", 32'(level), 32'd8);
      end

      // Commit frees three; a write in the same cycle is still dropped.
      cycle(1'b1, 8'h0A, 1'b0, 1'b1, 1'b0);
      chk("cm_full",   32'(full), 32'd0);
      chk("cm_level",  32'(level), 32'd5);
      chk("cm_dout",   32'(d_out), 32'h04);
      chk("cm_afull",  32'(almost_full), 32'd0);
      chk("cm_afull2", 32'(almost_full_2), 32'd1);

      // Two speculative reads, then rewind.
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("rd1_dout", 32'(d_out), 32'h05);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("rd2_dout", 32'(d_out), 32'h06);
      chk("rd2_aempty", 32'(almost_empty), 32'd0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("rw_dout",   32'(d_out), 32'h04);
      chk("rw_aempty", 32'(almost_empty), 32'd0);
      chk("rw_empty",  32'(empty), 32'd0);
      chk("rw_level",  32'(level), 32'd5);

      // Rewind wins over commit and shift_out in the same cycle.
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("pri_pre_dout", 32'(d_out), 32'h05);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      chk("pri_dout",  32'(d_out), 32'h04);
      chk("pri_level", 32'(level), 32'd5);
      // Commit with a read releases exactly one entry from the unchanged cptr.
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("pri_cm_dout",  32'(d_out), 32'h05);
      chk("pri_cm_level", 32'(level), 32'd4);

      // Streaming across the wrap: level stays at 4, order preserved.
      q = '{8'h05, 8'h06, 8'h07, 8'h08};
      for (int i = 0; i < 20; i++) begin
         chk("stream_dout", 32'(d_out), 32'(q[0]));
         cycle(1'b1, 8'(8'h10 + i), 1'b1, 1'b1, 1'b0);
         void'(q.pop_front());
         q.push_back(8'(8'h10 + i));
         chk("stream_full",  32'(full), 32'd0);
         chk("stream_level", 32'(level), 32'd4);
      end

      // Reset mid-stream, observed without a clock edge.
      shift_in  = 1'b1;
      d_in      = 8'h55;
      shift_out = 1'b1;
      commit    = 1'b1;
      #3 res_n = 1'b0;
      #1;
      chk("mrst_empty",  32'(empty), 32'd1);
      chk("mrst_level",  32'(level), 32'd0);
      chk("mrst_dout",   32'(d_out), 32'd0);
      chk("mrst_full",   32'(full), 32'd0);
      chk("mrst_aempty", 32'(almost_empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
      chk("mrst_err", 32'(err_overflow), 32'd0);
`endif
      @(posedge clk);
      #1;
      chk("mrst_hold_level", 32'(level), 32'd0);
      shift_in  = 1'b0;
      shift_out = 1'b0;
      commit    = 1'b0;
      res_n     = 1'b1;

      // Operation resumes after reset release.
      cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      chk("post_dout",  32'(d_out), 32'h33);
      chk("post_level", 32'(level), 32'd1);
      chk("post_empty", 32'(empty), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
